// File: rtl/noc_net_iface.sv
// -----------------------------------------------------------------------------
// noc_net_iface
//
// CPU-side network interface for the 2D mesh.
//
// Transmit path: CPU send requests are packed into 64-bit packets
// {dst_y[15:0], dst_x[15:0], data[31:0]}. They pass through a TX FIFO and a
// one-entry output register that drives the router injection port.
//
// Receive path: a router delivery is the rising edge of set_fi, with to_cpu
// sampled in that cycle. It is queued in an RX FIFO that the CPU drains.
//
// Handshake rule for every valid/ready pair in this block: a transfer happens
// on a rising clk edge where valid and ready are both 1. A producer holding
// valid keeps its data stable until that edge.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   tx_valid/tx_ready   CPU send request / TX FIFO not full
//   tx_dst_x/tx_dst_y   destination coordinates (unsigned 16-bit)
//   tx_data             signed payload, carried bit-exact
//   pkt_out/pkt_valid   packet to router, registered
//   pkt_ready           router accepts pkt_out
//   to_cpu, set_fi      router delivery data and delivery strobe
//   rx_data/rx_valid    RX FIFO head (0 when empty) / RX FIFO not empty
//   rx_pop              CPU consumes the RX head (ignored when empty)
//   rx_overflow         sticky: a delivery was dropped on a full RX FIFO
//   tx_self             sticky: a send addressed to this node was accepted
// -----------------------------------------------------------------------------
module noc_net_iface #(
    parameter int TX_DEPTH = 4,
    parameter int RX_DEPTH = 4,
    parameter int NODE_X   = 1,
    parameter int NODE_Y   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tx_valid,
    output logic        tx_ready,
    input  logic [15:0] tx_dst_x,
    input  logic [15:0] tx_dst_y,
    input  logic [31:0] tx_data,
    output logic [63:0] pkt_out,
    output logic        pkt_valid,
    input  logic        pkt_ready,
    input  logic [31:0] to_cpu,
    input  logic        set_fi,
    output logic [31:0] rx_data,
    output logic        rx_valid,
    input  logic        rx_pop,
    output logic        rx_overflow,
    output logic        tx_self
);

    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int TX_CW = TX_AW + 1;
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int RX_CW = RX_AW + 1;

    localparam logic [TX_CW-1:0] TX_FULL = TX_CW'(TX_DEPTH);
    localparam logic [RX_CW-1:0] RX_FULL = RX_CW'(RX_DEPTH);
    localparam logic [15:0]      SELF_X  = 16'(NODE_X);
    localparam logic [15:0]      SELF_Y  = 16'(NODE_Y);

    // ------------------------------------------------------------------
    // TX path
    // ------------------------------------------------------------------
    logic [63:0]      tx_mem [TX_DEPTH];
    logic [TX_AW-1:0] tx_wr_ptr;
    logic [TX_AW-1:0] tx_rd_ptr;
    logic [TX_CW-1:0] tx_count;

    logic [63:0] tx_word;
    logic        tx_push;
    logic        tx_load;
    logic        tx_pop;
    logic        tx_bypass;
    logic        tx_store;
    logic        tx_is_self;

    assign tx_word    = {tx_dst_y, tx_dst_x, tx_data};
    assign tx_ready   = (tx_count != TX_FULL);
    assign tx_push    = tx_valid && tx_ready;
    // The output register can take a new packet when it is empty or when
    // its current packet is leaving on this edge.
    assign tx_load    = !pkt_valid || pkt_ready;
    assign tx_pop     = tx_load && (tx_count != '0);
    // With an empty FIFO, a push goes straight into the output register.
    // This gives a one-cycle latency from push to pkt_valid.
    assign tx_bypass  = tx_load && (tx_count == '0) && tx_push;
    assign tx_store   = tx_push && !tx_bypass;
    assign tx_is_self = (tx_dst_x == SELF_X) && (tx_dst_y == SELF_Y);

    always_ff @(posedge clk) begin
        if (tx_store) begin
            tx_mem[tx_wr_ptr] <= tx_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
            pkt_out   <= '0;
            pkt_valid <= 1'b0;
            tx_self   <= 1'b0;
        end else begin
            if (tx_store) begin
                tx_wr_ptr <= tx_wr_ptr + TX_AW'(1);
            end
            if (tx_pop) begin
                tx_rd_ptr <= tx_rd_ptr + TX_AW'(1);
            end
            case ({tx_store, tx_pop})
                2'b10:   tx_count <= tx_count + TX_CW'(1);
                2'b01:   tx_count <= tx_count - TX_CW'(1);
                default: tx_count <= tx_count;
            endcase

            if (tx_load) begin
                if (tx_pop) begin
                    pkt_out   <= tx_mem[tx_rd_ptr];
                    pkt_valid <= 1'b1;
                end else if (tx_bypass) begin
                    pkt_out   <= tx_word;
                    pkt_valid <= 1'b1;
                end else begin
                    pkt_valid <= 1'b0;
                end
            end

            // A loopback send is still legal; it is flagged but not blocked.
            if (tx_push && tx_is_self) begin
                tx_self <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // RX path
    // ------------------------------------------------------------------
    logic [31:0]      rx_mem [RX_DEPTH];
    logic [RX_AW-1:0] rx_wr_ptr;
    logic [RX_AW-1:0] rx_rd_ptr;
    logic [RX_CW-1:0] rx_count;
    logic             set_fi_q;

    logic rx_rise;
    logic rx_do_pop;
    logic rx_full;
    logic rx_push;

    assign rx_rise   = set_fi && !set_fi_q;
    assign rx_do_pop = rx_pop && (rx_count != '0);
    assign rx_full   = (rx_count == RX_FULL);
    // A pop in the same cycle frees a slot, so a full FIFO still captures.
    assign rx_push   = rx_rise && (!rx_full || rx_do_pop);

    assign rx_valid  = (rx_count != '0);
    assign rx_data   = rx_valid ? rx_mem[rx_rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rx_push) begin
            rx_mem[rx_wr_ptr] <= to_cpu;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_wr_ptr   <= '0;
            rx_rd_ptr   <= '0;
            rx_count    <= '0;
            set_fi_q    <= 1'b0;
            rx_overflow <= 1'b0;
        end else begin
            set_fi_q <= set_fi;
            if (rx_push) begin
                rx_wr_ptr <= rx_wr_ptr + RX_AW'(1);
            end
            if (rx_do_pop) begin
                rx_rd_ptr <= rx_rd_ptr + RX_AW'(1);
            end
            case ({rx_push, rx_do_pop})
                2'b10:   rx_count <= rx_count + RX_CW'(1);
                2'b01:   rx_count <= rx_count - RX_CW'(1);
                default: rx_count <= rx_count;
            endcase
            if (rx_rise && rx_full && !rx_do_pop) begin
                rx_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_noc_net_iface.sv
// -----------------------------------------------------------------------------
// tb_noc_net_iface
//
// Directed scenarios plus a randomized run. The randomized run is checked
// against a queue-based reference model of the interface. Inputs change 1 ns
// after the rising edge. Outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_noc_net_iface;

    localparam int TX_DEPTH = 4;
    localparam int RX_DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        tx_valid;
    logic        tx_ready;
    logic [15:0] tx_dst_x;
    logic [15:0] tx_dst_y;
    logic [31:0] tx_data;
    logic [63:0] pkt_out;
    logic        pkt_valid;
    logic        pkt_ready;
    logic [31:0] to_cpu;
    logic        set_fi;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        rx_pop;
    logic        rx_overflow;
    logic        tx_self;

    int n_tests;
    int n_fail;

    noc_net_iface #(
        .TX_DEPTH(TX_DEPTH),
        .RX_DEPTH(RX_DEPTH),
        .NODE_X  (1),
        .NODE_Y  (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_dst_x   (tx_dst_x),
        .tx_dst_y   (tx_dst_y),
        .tx_data    (tx_data),
        .pkt_out    (pkt_out),
        .pkt_valid  (pkt_valid),
        .pkt_ready  (pkt_ready),
        .to_cpu     (to_cpu),
        .set_fi     (set_fi),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_pop     (rx_pop),
        .rx_overflow(rx_overflow),
        .tx_self    (tx_self)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        tx_valid  = 1'b0;
        tx_dst_x  = '0;
        tx_dst_y  = '0;
        tx_data   = '0;
        pkt_ready = 1'b0;
        to_cpu    = '0;
        set_fi    = 1'b0;
        rx_pop    = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #2;
        n_tests++;
        if (pkt_valid !== 1'b0 || pkt_out !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_pkt: pkt_valid=%b pkt_out=%h want 0/0", pkt_valid, pkt_out);
        end
        n_tests++;
        if (tx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_tx_ready: got %b want 1", tx_ready);
        end
        n_tests++;
        if (rx_valid !== 1'b0 || rx_data !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_rx: rx_valid=%b rx_data=%h want 0/0", rx_valid, rx_data);
        end
        n_tests++;
        if (rx_overflow !== 1'b0 || tx_self !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: rx_overflow=%b tx_self=%b want 0/0", rx_overflow, tx_self);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single_send();
        tx_valid  = 1'b1;
        tx_dst_x  = 16'd2;
        tx_dst_y  = 16'd1;
        tx_data   = 32'hFFFF_FFFB;
        pkt_ready = 1'b1;
        tick();
        tx_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (pkt_valid !== 1'b1 || pkt_out !== 64'h0001_0002_FFFF_FFFB) begin
            n_fail++;
            $display("FAIL single_send: pkt_valid=%b pkt_out=%h want 1/0001_0002_fffffffb",
                     pkt_valid, pkt_out);
        end
        tick();
        @(negedge clk);
        n_tests++;
        if (pkt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_send_drain: pkt_valid=%b want 0", pkt_valid);
        end
        idle_inputs();
    endtask

    task automatic test_backpressure();
        logic [63:0] p [5];
        apply_reset();
        pkt_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            p[i]     = {16'($urandom), 16'($urandom), 32'($urandom)};
            tx_dst_y = p[i][63:48];
            tx_dst_x = p[i][47:32];
            tx_data  = p[i][31:0];
            tx_valid = 1'b1;
            @(negedge clk);
            n_tests++;
            if (tx_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_ready_push%0d: tx_ready=%b want 1", i, tx_ready);
            end
            tick();
        end
        tx_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (tx_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_full: tx_ready=%b want 0", tx_ready);
        end
        n_tests++;
        if (pkt_valid !== 1'b1 || pkt_out !== p[0]) begin
            n_fail++;
            $display("FAIL bp_hold: pkt_valid=%b pkt_out=%h want 1/%h", pkt_valid, pkt_out, p[0]);
        end
        tick();
        pkt_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_tests++;
            if (pkt_valid !== 1'b1 || pkt_out !== p[i]) begin
                n_fail++;
                $display("FAIL bp_drain%0d: pkt_valid=%b pkt_out=%h want 1/%h",
                         i, pkt_valid, pkt_out, p[i]);
            end
            tick();
        end
        @(negedge clk);
        n_tests++;
        if (pkt_valid !== 1'b0 || tx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_empty: pkt_valid=%b tx_ready=%b want 0/1", pkt_valid, tx_ready);
        end
        idle_inputs();
    endtask

    task automatic test_rx_capture();
        apply_reset();
        to_cpu = 32'd123;
        set_fi = 1'b1;
        repeat (3) tick();
        set_fi = 1'b0;
        tick();
        @(negedge clk);
        n_tests++;
        if (rx_valid !== 1'b1 || rx_data !== 32'd123) begin
            n_fail++;
            $display("FAIL rx_capture: rx_valid=%b rx_data=%0d want 1/123", rx_valid, rx_data);
        end
        rx_pop = 1'b1;
        tick();
        rx_pop = 1'b0;
        @(negedge clk);
        n_tests++;
        if (rx_valid !== 1'b0 || rx_data !== 32'd0) begin
            n_fail++;
            $display("FAIL rx_single_entry: rx_valid=%b rx_data=%0d want 0/0", rx_valid, rx_data);
        end
        idle_inputs();
    endtask

    task automatic test_rx_overflow();
        apply_reset();
        for (int v = 1; v <= 5; v++) begin
            to_cpu = 32'(v);
            set_fi = 1'b1;
            tick();
            set_fi = 1'b0;
            tick();
        end
        @(negedge clk);
        n_tests++;
        if (rx_overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL rx_overflow_flag: got %b want 1", rx_overflow);
        end
        for (int v = 1; v <= 4; v++) begin
            @(negedge clk);
            n_tests++;
            if (rx_valid !== 1'b1 || rx_data !== 32'(v)) begin
                n_fail++;
                $display("FAIL rx_overflow_pop%0d: rx_valid=%b rx_data=%0d want 1/%0d",
                         v, rx_valid, rx_data, v);
            end
            rx_pop = 1'b1;
            tick();
            rx_pop = 1'b0;
        end
        @(negedge clk);
        n_tests++;
        if (rx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rx_overflow_lost: rx_valid=%b want 0", rx_valid);
        end
        idle_inputs();
    endtask

    task automatic test_rx_full_pop();
        logic [31:0] exp_vals [4];
        exp_vals[0] = 32'd12;
        exp_vals[1] = 32'd13;
        exp_vals[2] = 32'd14;
        exp_vals[3] = 32'd9;
        apply_reset();
        for (int v = 11; v <= 14; v++) begin
            to_cpu = 32'(v);
            set_fi = 1'b1;
            tick();
            set_fi = 1'b0;
            tick();
        end
        to_cpu = 32'd9;
        set_fi = 1'b1;
        rx_pop = 1'b1;
        tick();
        set_fi = 1'b0;
        rx_pop = 1'b0;
        @(negedge clk);
        n_tests++;
        if (rx_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL rx_full_pop_ovf: rx_overflow=%b want 0", rx_overflow);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_tests++;
            if (rx_valid !== 1'b1 || rx_data !== exp_vals[i]) begin
                n_fail++;
                $display("FAIL rx_full_pop%0d: rx_valid=%b rx_data=%0d want 1/%0d",
                         i, rx_valid, rx_data, exp_vals[i]);
            end
            rx_pop = 1'b1;
            tick();
            rx_pop = 1'b0;
        end
        @(negedge clk);
        n_tests++;
        if (rx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rx_full_pop_empty: rx_valid=%b want 0", rx_valid);
        end
        idle_inputs();
    endtask

    task automatic test_loopback();
        logic [31:0] d;
        apply_reset();
        d         = $urandom;
        tx_valid  = 1'b1;
        tx_dst_x  = 16'd1;
        tx_dst_y  = 16'd1;
        tx_data   = d;
        pkt_ready = 1'b1;
        tick();
        tx_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (tx_self !== 1'b1) begin
            n_fail++;
            $display("FAIL loopback_flag: tx_self=%b want 1", tx_self);
        end
        n_tests++;
        if (pkt_valid !== 1'b1 || pkt_out !== {16'd1, 16'd1, d}) begin
            n_fail++;
            $display("FAIL loopback_pkt: pkt_valid=%b pkt_out=%h want 1/%h",
                     pkt_valid, pkt_out, {16'd1, 16'd1, d});
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        apply_reset();
        pkt_ready = 1'b0;
        tx_valid  = 1'b1;
        tx_dst_x  = 16'd1;
        tx_dst_y  = 16'd1;
        for (int i = 0; i < 3; i++) begin
            tx_data = $urandom;
            to_cpu  = $urandom;
            set_fi  = (i % 2 == 0);
            tick();
        end
        tx_valid = 1'b0;
        set_fi   = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (pkt_valid !== 1'b0 || pkt_out !== 64'd0 || tx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset_tx: pkt_valid=%b pkt_out=%h tx_ready=%b want 0/0/1",
                     pkt_valid, pkt_out, tx_ready);
        end
        n_tests++;
        if (rx_valid !== 1'b0 || tx_self !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_rx: rx_valid=%b tx_self=%b want 0/0", rx_valid, tx_self);
        end
        apply_reset();
    endtask

    // ---------------- reference model + randomized run ----------------
    // The model treats the interface as one ordered queue of in-flight packets.
    // It can hold up to TX_DEPTH + 1 packets, because the output stage holds
    // one packet. The head of this queue is what pkt_out must show.
    logic [63:0] exp_q [$];
    logic [31:0] rx_q  [$];
    bit          m_prev_fi;
    bit          m_ovf;
    bit          m_self;

    task automatic test_random();
        bit          e_pv;
        bit          e_tr;
        bit          e_rv;
        logic [31:0] e_rd;
        bit          rise;
        apply_reset();
        exp_q.delete();
        rx_q.delete();
        m_prev_fi = 1'b0;
        m_ovf     = 1'b0;
        m_self    = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            tx_valid  = ($urandom_range(0, 9) < 7);
            tx_dst_x  = 16'($urandom_range(0, 3));
            tx_dst_y  = 16'($urandom_range(0, 3));
            tx_data   = $urandom;
            pkt_ready = ($urandom_range(0, 1) == 1);
            set_fi    = ($urandom_range(0, 1) == 1);
            to_cpu    = $urandom;
            rx_pop    = ($urandom_range(0, 9) < 3);
            @(negedge clk);

            e_pv = (exp_q.size() != 0);
            e_tr = (exp_q.size() < TX_DEPTH + 1);
            e_rv = (rx_q.size() != 0);
            e_rd = e_rv ? rx_q[0] : 32'd0;

            n_tests++;
            if (pkt_valid !== e_pv || (e_pv && pkt_out !== exp_q[0])) begin
                n_fail++;
                $display("FAIL rand_pkt c%0d: pkt_valid=%b pkt_out=%h want %b/%h",
                         cyc, pkt_valid, pkt_out, e_pv, e_pv ? exp_q[0] : 64'd0);
            end
            n_tests++;
            if (tx_ready !== e_tr) begin
                n_fail++;
                $display("FAIL rand_tx_ready c%0d: got %b want %b", cyc, tx_ready, e_tr);
            end
            n_tests++;
            if (rx_valid !== e_rv || rx_data !== e_rd) begin
                n_fail++;
                $display("FAIL rand_rx c%0d: rx_valid=%b rx_data=%h want %b/%h",
                         cyc, rx_valid, rx_data, e_rv, e_rd);
            end
            n_tests++;
            if (rx_overflow !== m_ovf || tx_self !== m_self) begin
                n_fail++;
                $display("FAIL rand_flags c%0d: rx_overflow=%b tx_self=%b want %b/%b",
                         cyc, rx_overflow, tx_self, m_ovf, m_self);
            end

            // Advance the model across the coming edge.
            if (e_pv && pkt_ready) void'(exp_q.pop_front());
            if (tx_valid && e_tr) begin
                exp_q.push_back({tx_dst_y, tx_dst_x, tx_data});
                if (tx_dst_x == 16'd1 && tx_dst_y == 16'd1) m_self = 1'b1;
            end
            rise      = set_fi && !m_prev_fi;
            m_prev_fi = set_fi;
            if (rx_pop && rx_q.size() != 0) void'(rx_q.pop_front());
            if (rise) begin
                if (rx_q.size() < RX_DEPTH) rx_q.push_back(to_cpu);
                else m_ovf = 1'b1;
            end
            tick();
        end
        idle_inputs();
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        n_tests = 0;
        n_fail  = 0;
        idle_inputs();
        rst_n = 1'b0;
        #1;
        test_reset();
        test_single_send();
        test_backpressure();
        test_rx_capture();
        test_rx_overflow();
        test_rx_full_pop();
        test_loopback();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
